// File: rtl/vga_scanout_if.sv
// ---------------------------------------------------------------------------
// vga_scanout_if
//
// Bundle between the display timing stage and its neighbours.
//
//   Raster side (to / from the sprite cluster):
//     x, y         current raster coordinates, driven by the scanout stage
//     pixel        cluster colour for (x, y), driven by the cluster
//
//   VGA pin side (all registered in the scanout stage):
//     vga_r/g/b    colour channels, COLOR_WIDTH/3 bits each
//     vga_hs/vs    horizontal / vertical sync
//     de           data enable, 1 inside the active area
//     vblank       1 while the current line is below the active area
//     frame_start  one-clk pulse when the raster wraps to (0,0)
//
// Handshake: there is no valid/ready pair. The raster coordinates are held
// stable for a whole pixel period, and the cluster must present a settled
// `pixel` by the last clk of that period. The scanout stage samples it
// unconditionally on that clk.
//
// Modports:
//   master - the scanout stage (drives coordinates and pins, reads pixel)
//   slave  - the cluster / observers (reads coordinates and pins, drives pixel)
// ---------------------------------------------------------------------------
interface vga_scanout_if #(
  parameter int INT_WIDTH   = 16,
  parameter int COLOR_WIDTH = 12
);

  localparam int CH_W = COLOR_WIDTH / 3;

  logic [INT_WIDTH-1:0]   x;
  logic [INT_WIDTH-1:0]   y;
  logic [COLOR_WIDTH-1:0] pixel;
  logic [CH_W-1:0]        vga_r;
  logic [CH_W-1:0]        vga_g;
  logic [CH_W-1:0]        vga_b;
  logic                   vga_hs;
  logic                   vga_vs;
  logic                   de;
  logic                   vblank;
  logic                   frame_start;

  modport master (
    output x,
    output y,
    input  pixel,
    output vga_r,
    output vga_g,
    output vga_b,
    output vga_hs,
    output vga_vs,
    output de,
    output vblank,
    output frame_start
  );

  modport slave (
    input  x,
    input  y,
    output pixel,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vga_hs,
    input  vga_vs,
    input  de,
    input  vblank,
    input  frame_start
  );

endinterface

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// Display timing and scan-out stage. Runs the horizontal / vertical raster
// counters, presents them as x/y to the sprite cluster, and on the last clk
// of every pixel period captures the cluster colour together with sync,
// data-enable and blanking into output flops. Also exports vblank and a
// frame_start pulse so that writers into the cluster can confine their
// updates to blanking.
//
// Ports:
//   clk   in   system clock, the only clock
//   rst   in   synchronous, active-low reset
//   bus   master modport of vga_scanout_if:
//           x, y          out  raster counters (zero-extended, flop outputs)
//           pixel         in   cluster colour for the current (x, y)
//           vga_r/g/b     out  registered colour, R = MSB third of pixel
//           vga_hs/vs     out  registered sync, asserted level = SYNC_POL
//           de            out  registered data enable
//           vblank        out  registered, 1 while vcnt >= V_ACTIVE
//           frame_start   out  one-clk pulse as the raster wraps to (0,0)
//
// Every VGA output lags x/y by exactly one pixel period: the values for
// coordinate n appear on the clk after the tick that ends period n.
// ---------------------------------------------------------------------------
module vga_scanout #(
  parameter int INT_WIDTH   = 16,
  parameter int COLOR_WIDTH = 12,
  parameter int PIX_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  vga_scanout_if.master  bus
);

  // -------------------------------------------------------------------------
  // Derived timing constants
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int CH_W    = COLOR_WIDTH / 3;

  // A one-bit divider is kept even when PIX_DIV is 1; it then sits at 0 and
  // the tick compare is constantly true.
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [INT_WIDTH-1:0] H_LAST   = INT_WIDTH'(H_TOTAL - 1);
  localparam logic [INT_WIDTH-1:0] V_LAST   = INT_WIDTH'(V_TOTAL - 1);
  localparam logic [INT_WIDTH-1:0] H_ACT    = INT_WIDTH'(H_ACTIVE);
  localparam logic [INT_WIDTH-1:0] V_ACT    = INT_WIDTH'(V_ACTIVE);
  localparam logic [INT_WIDTH-1:0] HS_START = INT_WIDTH'(H_ACTIVE + H_FRONT);
  localparam logic [INT_WIDTH-1:0] HS_END   = INT_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [INT_WIDTH-1:0] VS_START = INT_WIDTH'(V_ACTIVE + V_FRONT);
  localparam logic [INT_WIDTH-1:0] VS_END   = INT_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  // -------------------------------------------------------------------------
  // Pixel-period divider
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  logic [INT_WIDTH-1:0] hcnt_q;
  logic [INT_WIDTH-1:0] vcnt_q;
  logic                 h_last;
  logic                 v_last;

  assign h_last = (hcnt_q == H_LAST);
  assign v_last = (vcnt_q == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (tick) begin
      if (h_last) begin
        hcnt_q <= '0;
        vcnt_q <= v_last ? '0 : vcnt_q + INT_WIDTH'(1);
      end else begin
        hcnt_q <= hcnt_q + INT_WIDTH'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Decode of the current (pre-advance) raster position. These are what
  // the output flops capture on tick.
  // -------------------------------------------------------------------------
  logic            active;
  logic            hs_on;
  logic            vs_on;
  logic            in_vblank;
  logic            wrap;
  logic [CH_W-1:0] r_next;
  logic [CH_W-1:0] g_next;
  logic [CH_W-1:0] b_next;

  always_comb begin
    active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_on     = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    vs_on     = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
    in_vblank = (vcnt_q >= V_ACT);
    // Last pixel of the last line, on its final clk: the raster is about
    // to return to (0,0).
    wrap      = tick && h_last && v_last;

    // Colour is forced to black outside the active area; the cluster's
    // output is meaningless there.
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (active) begin
      r_next = bus.pixel[3*CH_W-1 -: CH_W];
      g_next = bus.pixel[2*CH_W-1 -: CH_W];
      b_next = bus.pixel[CH_W-1   -: CH_W];
    end
  end

  // -------------------------------------------------------------------------
  // Output registers. All VGA pins update together, only on tick, so they
  // change exactly once per pixel period.
  // -------------------------------------------------------------------------
  logic [CH_W-1:0] r_q;
  logic [CH_W-1:0] g_q;
  logic [CH_W-1:0] b_q;
  logic            hs_q;
  logic            vs_q;
  logic            de_q;
  logic            vblank_q;
  logic            frame_start_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hs_q     <= SYNC_OFF;
      vs_q     <= SYNC_OFF;
      de_q     <= 1'b0;
      vblank_q <= 1'b0;
    end else if (tick) begin
      r_q      <= r_next;
      g_q      <= g_next;
      b_q      <= b_next;
      hs_q     <= hs_on ? SYNC_ON : SYNC_OFF;
      vs_q     <= vs_on ? SYNC_ON : SYNC_OFF;
      de_q     <= active;
      vblank_q <= in_vblank;
    end
  end

  // frame_start is rewritten every clk so it is high for exactly the one
  // clk in which x/y read (0,0) after a natural wrap. A reset restart never
  // passes through `wrap`, so it emits no pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= wrap;
    end
  end

  // -------------------------------------------------------------------------
  // Port drive: every output is a flop.
  // -------------------------------------------------------------------------
  assign bus.x           = hcnt_q;
  assign bus.y           = vcnt_q;
  assign bus.vga_r       = r_q;
  assign bus.vga_g       = g_q;
  assign bus.vga_b       = b_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.de          = de_q;
  assign bus.vblank      = vblank_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display timing and scan-out stage for the GPU. It runs the horizontal and vertical raster counters and drives the `x`/`y` coordinates into the sprite cluster. It samples the cluster's `pixel` result once per pixel period and registers it, together with the sync and blanking signals, onto the VGA pins. It also exports `vblank` and a `frame_start` pulse, so that writers to the cluster write port (positions and textures) can confine their updates to blanking.

## Interface

Parameters:
- `INT_WIDTH`, 16: width of the `x`/`y` coordinate outputs and of the internal counters.
- `COLOR_WIDTH`, 12: width of the incoming `pixel`; must be divisible by 3 (R = MSB third, G = middle third, B = LSB third).
- `PIX_DIV`, 2: clk cycles per pixel; must be ≥ 1.
- `H_ACTIVE`, `H_FRONT`, `H_SYNC`, `H_BACK`: 640, 16, 96, 48.
- `V_ACTIVE`, `V_FRONT`, `V_SYNC`, `V_BACK`: 480, 10, 2, 33.
- `SYNC_POL`, 0: asserted level of `vga_hs`/`vga_vs` (0 = active-low).

Ports:
- `clk` input, 1: system clock; the only clock.
- `rst` input, 1: synchronous, active-low reset.
- `x` output, INT_WIDTH: current horizontal count, to the cluster.
- `y` output, INT_WIDTH: current vertical count, to the cluster.
- `pixel` input, COLOR_WIDTH: cluster colour for the current (`x`,`y`).
- `vga_r`, `vga_g`, `vga_b` output, COLOR_WIDTH/3 each: registered colour channels.
- `vga_hs` output, 1: registered horizontal sync.
- `vga_vs` output, 1: registered vertical sync.
- `de` output, 1: registered data-enable; 1 inside the active area.
- `vblank` output, 1: registered; 1 while the current line `vcnt` is ≥ V_ACTIVE.
- `frame_start` output, 1: one-clk pulse when the raster wraps to (0,0).

## Operation

Totals:
- H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK.
- V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK.

Counters and pixel tick:
- `div` counts 0..PIX_DIV-1 and wraps.
- `tick` = (`div` == PIX_DIV-1). With PIX_DIV = 1, `tick` is always 1.
- `hcnt` counts 0..H_TOTAL-1 and advances on `tick`.
- At `hcnt` == H_TOTAL-1, `hcnt` goes to 0 and `vcnt` advances.
- `vcnt` counts 0..V_TOTAL-1 and wraps to 0 after V_TOTAL-1.
- `x` = `hcnt` and `y` = `vcnt`, zero-extended and continuously driven. They are stable for the whole pixel period, including in blanking, where the cluster output is ignored.

Pixel capture on `tick`, computed from the pre-advance `hcnt`/`vcnt`:
- Active area: `active` = (`hcnt` < H_ACTIVE) && (`vcnt` < V_ACTIVE).
- `de` ← `active`.
- When `active`, {`vga_r`,`vga_g`,`vga_b`} ← `pixel`; otherwise all channels ← 0.
- `vga_hs` ← SYNC_POL when H_ACTIVE+H_FRONT ≤ `hcnt` < H_ACTIVE+H_FRONT+H_SYNC; otherwise ← !SYNC_POL.
- `vga_vs` ← SYNC_POL when V_ACTIVE+V_FRONT ≤ `vcnt` < V_ACTIVE+V_FRONT+V_SYNC; otherwise ← !SYNC_POL.
- `vblank` ← (`vcnt` ≥ V_ACTIVE).

Frame pulse:
- `frame_start` = 1 for exactly one clk: the cycle after the tick on which (`hcnt`,`vcnt`) = (H_TOTAL-1, V_TOTAL-1).
- It is 0 at all other times.

Reset (`rst` = 0 at a clk edge; dominates everything else):
- Outputs: `div`, `hcnt`, `vcnt` = 0, so `x`/`y` = 0.
- RGB = 0, `de` = 0, `vblank` = 0, `frame_start` = 0.
- `vga_hs` = `vga_vs` = !SYNC_POL.
- Mid-frame reset abandons the frame. The first cycle after release starts a fresh frame at (0,0), `div` = 0.
- No `frame_start` is emitted for this restart.

## Timing

- The cluster's `pixel` must be valid within PIX_DIV-1 clk after `x`/`y` change. At the default of 2, that is 1 cycle: one registered texture read.
- PIX_DIV = 1 requires a combinational `pixel` path.
- VGA outputs lag `x`/`y` by exactly one pixel period: the value for coordinate n appears at the clk after the tick that ends period n.
- All VGA outputs change only on the clk following a `tick`, and all change together.
- Every output comes directly from a flop; there are no combinational paths to outputs except `x`/`y`, which are counter flops.
- Sync widths, in clk cycles:
  - hs: H_SYNC·PIX_DIV.
  - vs: V_SYNC·H_TOTAL·PIX_DIV.
- Frame period: H_TOTAL·V_TOTAL·PIX_DIV clk. At the defaults this is 800·525·2 = 840000.

## Test plan

- **Reset release:** hold `rst` = 0 for 5 clk. → `x` = `y` = 0; RGB = 0; `de` = 0; `vga_hs` = `vga_vs` = 1; `vblank` = 0; `frame_start` = 0.
- **First pixel:** release reset with `pixel` = 0xABC. → After 2 clk, RGB = A/B/C and `de` = 1. `x` = 1 after 2 clk, `x` = 2 after 4 clk.
- **Horizontal timing:** run one line. →
  - `vga_hs` is low for exactly 192 clk.
  - The falling edge is 2 clk after `x` becomes 656.
  - `de` drops 2 clk after `x` becomes 640.
  - RGB = 0 while `de` = 0, even with `pixel` = 0xFFF.
- **Frame wrap:** run 840000 clk. →
  - `vga_vs` is low for 2 lines (3200 clk), starting at `y` = 490.
  - `vblank` is 1 from `y` = 480 (registered) through `y` = 524.
  - `frame_start` pulses once, for 1 clk, as `x`/`y` return to 0.
- **Mid-frame reset:** reset at `y` = 200, `x` = 300 for 1 clk. →
  - Next cycle: all outputs are at their reset values; counters are 0.
  - No `frame_start` pulse occurs.
  - The next frame is full length.
- **PIX_DIV = 1 build, `pixel` = 0x00F:** →
  - `x` increments every clk.
  - `vga_hs` is low for 96 clk.
  - RGB = 0/0/F one clk after each active coordinate.
